program_loader: RTL

- Boot-time loader directly upstream of the CPU's instruction memory.
- Receives a byte stream over a valid/ready handshake and frames it into a header, payload and checksum.
- Assembles big-endian 32-bit instruction words and issues one write per word into instruction memory.
- Holds the CPU in reset until a complete image with a correct checksum has been written.

---
 rtl/program_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: frames a byte stream (count header, payload, XOR checksum)
// into big-endian 32-bit instruction-memory writes and holds the CPU in reset until the image checks out.
module program_loader #(
    parameter int INSTR_MEM_SIZE = 1024,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        PAYLOAD,
        CHECKSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [COUNT_WIDTH:0] MAX_COUNT = (COUNT_WIDTH + 1)'(INSTR_MEM_SIZE);
    localparam int ADDR_PAD = 32 - COUNT_WIDTH - 2;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] word_count;
    logic [COUNT_WIDTH-1:0] word_index;
    logic [1:0]             lane;
    logic [23:0]            word_buf;
    logic [7:0]             checksum;
    logic                   accept;
    logic [COUNT_WIDTH-1:0] header_count;

    // Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both 1;
    // byte_ready is registered and drops for good once the loader reaches DONE or ERROR.
    assign accept       = byte_valid && byte_ready;
    assign header_count = {word_count[COUNT_WIDTH-1:8], byte_data};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= HDR_HI;
            byte_ready        <= 1'b0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= 32'h0;
            mem_write_data    <= 32'h0;
            cpu_reset         <= 1'b1;
            load_done         <= 1'b0;
            load_error        <= 1'b0;
            word_count        <= '0;
            word_index        <= '0;
            lane              <= 2'd0;
            word_buf          <= 24'h0;
            checksum          <= 8'h0;
        end else begin
            mem_write_enable <= 1'b0;
            if (state != DONE && state != ERROR) begin
                byte_ready <= 1'b1;
            end
            if (accept) begin
                case (state)
                    HDR_HI: begin
                        word_count <= COUNT_WIDTH'({byte_data, 8'h00});
                        state      <= HDR_LO;
                    end
                    HDR_LO: begin
                        word_count <= header_count;
                        if ({1'b0, header_count} > MAX_COUNT) begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                            byte_ready <= 1'b0;
                        end else if (header_count == '0) begin
                            state <= CHECKSUM;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        checksum <= checksum ^ byte_data;
                        if (lane == 2'd3) begin
                            // Upper three bytes were shifted in MSB-first; this byte is bits 7:0.
                            mem_write_data    <= {word_buf, byte_data};
                            mem_write_address <= {{ADDR_PAD{1'b0}}, word_index, 2'b00};
                            mem_write_enable  <= 1'b1;
                            word_index        <= word_index + COUNT_WIDTH'(1);
                            lane              <= 2'd0;
                            if (word_index == word_count - COUNT_WIDTH'(1)) begin
                                state <= CHECKSUM;
                            end
                        end else begin
                            word_buf <= {word_buf[15:0], byte_data};
                            lane     <= lane + 2'd1;
                        end
                    end
                    CHECKSUM: begin
                        byte_ready <= 1'b0;
                        if (byte_data == checksum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule
